// File: rtl/char_write_scheduler.sv
// Character/colour write scheduler: round-robin arbitration of two cell writers
// plus a full-grid clear sequence that drives both the character and highlight ports.
//
// state | meaning
// IDLE  | arbitrate A/B cell writes; clr_req starts a clear
// CLEAR | write one clear cell per cycle over the latched grid size
module char_write_scheduler #(
    parameter logic [6:0] CLR_ASCII  = 7'h20,
    parameter logic [5:0] CLR_COLOUR = 6'b111111,
    parameter logic       CLR_HL     = 1'b0
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       sL,
    input  logic       clr_req,
    input  logic       a_req,
    input  logic [6:0] a_x,
    input  logic [5:0] a_y,
    input  logic [6:0] a_ascii,
    input  logic [5:0] a_colour,
    output logic       a_ack,
    input  logic       b_req,
    input  logic [6:0] b_x,
    input  logic [5:0] b_y,
    input  logic [6:0] b_ascii,
    input  logic [5:0] b_colour,
    output logic       b_ack,
    output logic [6:0] wrx,
    output logic [5:0] wry,
    output logic       wren,
    output logic [6:0] wascii,
    output logic [5:0] wcolour,
    output logic [6:0] hix,
    output logic [5:0] hiy,
    output logic       hien,
    output logic       highlight,
    output logic       busy,
    output logic       clr_done
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t     state, state_nx;
    logic [6:0] cx, cx_nx;
    logic [5:0] cy, cy_nx;
    logic       sl_q, sl_nx;
    logic       last_b, last_b_nx;

    logic [6:0] wrx_nx, wascii_nx, hix_nx;
    logic [5:0] wry_nx, wcolour_nx, hiy_nx;
    logic       wren_nx, hien_nx, highlight_nx, a_ack_nx, b_ack_nx, busy_nx, clr_done_nx;

    logic       a_elig, b_elig, pick_a, clr_wr;
    logic [6:0] gx, lim_w, w_last;
    logic [5:0] gy, lim_h, h_last;

    // a requester whose ack is showing this cycle sits out one arbitration
    assign a_elig = a_req & ~a_ack;
    assign b_elig = b_req & ~b_ack;
    assign pick_a = a_elig & (~b_elig | last_b);
    assign gx     = pick_a ? a_x : b_x;
    assign gy     = pick_a ? a_y : b_y;
    assign lim_w  = sL ? 7'd40 : 7'd80;
    assign lim_h  = sL ? 6'd30 : 6'd60;
    assign w_last = sl_q ? 7'd39 : 7'd79;
    assign h_last = sl_q ? 6'd29 : 6'd59;

    always_comb begin
        state_nx     = state;
        cx_nx        = cx;
        cy_nx        = cy;
        sl_nx        = sl_q;
        last_b_nx    = last_b;
        clr_wr       = 1'b0;
        wrx_nx       = '0;
        wry_nx       = '0;
        wren_nx      = 1'b0;
        wascii_nx    = '0;
        wcolour_nx   = '0;
        hix_nx       = '0;
        hiy_nx       = '0;
        hien_nx      = 1'b0;
        highlight_nx = 1'b0;
        a_ack_nx     = 1'b0;
        b_ack_nx     = 1'b0;
        busy_nx      = 1'b0;
        clr_done_nx  = 1'b0;

        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nx = CLEAR;
                    sl_nx    = sL;
                    cx_nx    = '0;
                    cy_nx    = '0;
                    clr_wr   = 1'b1;
                end else if (a_elig || b_elig) begin
                    a_ack_nx   = pick_a;
                    b_ack_nx   = ~pick_a;
                    last_b_nx  = ~pick_a;
                    wrx_nx     = gx;
                    wry_nx     = gy;
                    wascii_nx  = pick_a ? a_ascii : b_ascii;
                    wcolour_nx = pick_a ? a_colour : b_colour;
                    wren_nx    = (gx < lim_w) && (gy < lim_h);
                end
            end
            CLEAR: begin
                // cx/cy hold the cell currently on the write ports
                if (cx == w_last && cy == h_last) begin
                    state_nx    = IDLE;
                    cx_nx       = '0;
                    cy_nx       = '0;
                    clr_done_nx = 1'b1;
                end else begin
                    clr_wr = 1'b1;
                    if (cx == w_last) begin
                        cx_nx = '0;
                        cy_nx = cy + 6'd1;
                    end else begin
                        cx_nx = cx + 7'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        if (clr_wr) begin
            wrx_nx       = cx_nx;
            wry_nx       = cy_nx;
            wren_nx      = 1'b1;
            wascii_nx    = CLR_ASCII;
            wcolour_nx   = CLR_COLOUR;
            hix_nx       = cx_nx;
            hiy_nx       = cy_nx;
            hien_nx      = 1'b1;
            highlight_nx = CLR_HL;
            busy_nx      = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cx        <= '0;
            cy        <= '0;
            sl_q      <= 1'b0;
            last_b    <= 1'b1;
            wrx       <= '0;
            wry       <= '0;
            wren      <= 1'b0;
            wascii    <= '0;
            wcolour   <= '0;
            hix       <= '0;
            hiy       <= '0;
            hien      <= 1'b0;
            highlight <= 1'b0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            busy      <= 1'b0;
            clr_done  <= 1'b0;
        end else begin
            state     <= state_nx;
            cx        <= cx_nx;
            cy        <= cy_nx;
            sl_q      <= sl_nx;
            last_b    <= last_b_nx;
            wrx       <= wrx_nx;
            wry       <= wry_nx;
            wren      <= wren_nx;
            wascii    <= wascii_nx;
            wcolour   <= wcolour_nx;
            hix       <= hix_nx;
            hiy       <= hiy_nx;
            hien      <= hien_nx;
            highlight <= highlight_nx;
            a_ack     <= a_ack_nx;
            b_ack     <= b_ack_nx;
            busy      <= busy_nx;
            clr_done  <= clr_done_nx;
        end
    end

endmodule

// File: tb/tb_char_write_scheduler.sv
// Bench for char_write_scheduler: cycle reference model built on cell indices,
// per-cycle output compare, directed scenarios and a randomized requester phase.
module tb_char_write_scheduler;

    localparam logic [6:0] CA = 7'h20;
    localparam logic [5:0] CC = 6'b111111;
    localparam logic       CH = 1'b0;

    logic       clock, resetn, sL, clr_req;
    logic       a_req, b_req;
    logic [6:0] a_x, a_ascii, b_x, b_ascii;
    logic [5:0] a_y, a_colour, b_y, b_colour;
    logic       a_ack, b_ack, wren, hien, highlight, busy, clr_done;
    logic [6:0] wrx, wascii, hix;
    logic [5:0] wry, wcolour, hiy;

    int checks = 0;
    int failures = 0;

    char_write_scheduler dut (
        .clock(clock), .resetn(resetn), .sL(sL), .clr_req(clr_req),
        .a_req(a_req), .a_x(a_x), .a_y(a_y), .a_ascii(a_ascii), .a_colour(a_colour), .a_ack(a_ack),
        .b_req(b_req), .b_x(b_x), .b_y(b_y), .b_ascii(b_ascii), .b_colour(b_colour), .b_ack(b_ack),
        .wrx(wrx), .wry(wry), .wren(wren), .wascii(wascii), .wcolour(wcolour),
        .hix(hix), .hiy(hiy), .hien(hien), .highlight(highlight),
        .busy(busy), .clr_done(clr_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // reference model: a clear is a run of cell indices 0..W*H-1, cell i = (i mod W, i div W)
    logic [6:0] e_wrx, e_wascii, e_hix;
    logic [5:0] e_wry, e_wcolour, e_hiy;
    logic       e_wren, e_hien, e_hl, e_a_ack, e_b_ack, e_busy, e_done;
    bit         m_clear = 0;
    bit         m_last_b = 1;
    bit         m_ea, m_eb, m_ga;
    int         m_idx = 0, m_total = 0, m_w = 80, m_gx, m_gy;

    task automatic model_zero();
        e_wrx = '0; e_wry = '0; e_wren = 0; e_wascii = '0; e_wcolour = '0;
        e_hix = '0; e_hiy = '0; e_hien = 0; e_hl = 0;
        e_a_ack = 0; e_b_ack = 0; e_busy = 0; e_done = 0;
    endtask

    task automatic model_cell(input int i);
        e_wrx = 7'(i % m_w);
        e_wry = 6'(i / m_w);
        e_wren = 1; e_wascii = CA; e_wcolour = CC;
        e_hix = e_wrx; e_hiy = e_wry; e_hien = 1; e_hl = CH; e_busy = 1;
    endtask

    initial model_zero();

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            model_zero();
            m_clear = 0; m_idx = 0; m_last_b = 1;
        end else begin
            m_ea = a_req && !e_a_ack;
            m_eb = b_req && !e_b_ack;
            model_zero();
            if (m_clear) begin
                if (m_idx == m_total) begin
                    e_done = 1; m_clear = 0;
                end else begin
                    model_cell(m_idx); m_idx++;
                end
            end else if (clr_req) begin
                m_w = sL ? 40 : 80;
                m_total = m_w * (sL ? 30 : 60);
                m_clear = 1;
                model_cell(0); m_idx = 1;
            end else if (m_ea || m_eb) begin
                m_ga = m_ea && (!m_eb || m_last_b);
                m_last_b = !m_ga;
                if (m_ga) begin
                    e_a_ack = 1; e_wrx = a_x; e_wry = a_y; e_wascii = a_ascii; e_wcolour = a_colour;
                end else begin
                    e_b_ack = 1; e_wrx = b_x; e_wry = b_y; e_wascii = b_ascii; e_wcolour = b_colour;
                end
                m_gx = int'(e_wrx);
                m_gy = int'(e_wry);
                e_wren = (m_gx < (sL ? 40 : 80)) && (m_gy < (sL ? 30 : 60));
            end
        end
    end

    logic [45:0] dut_vec, exp_vec;
    assign dut_vec = {wrx, wry, wren, wascii, wcolour, hix, hiy, hien, highlight, a_ack, b_ack, busy, clr_done};
    assign exp_vec = {e_wrx, e_wry, e_wren, e_wascii, e_wcolour, e_hix, e_hiy, e_hien, e_hl,
                      e_a_ack, e_b_ack, e_busy, e_done};

    always @(negedge clock) check("cycle_outputs", 64'(dut_vec), 64'(exp_vec));

    int  writes, last_cyc, done_cyc, busy_bad, ack_during, bad_done, bad_wr, nclr;
    logic [6:0] lastx;
    logic [5:0] lasty;
    bit  done_seen, hit;

    initial begin
        resetn = 1; sL = 0; clr_req = 0;
        a_req = 0; a_x = '0; a_y = '0; a_ascii = '0; a_colour = '0;
        b_req = 0; b_x = '0; b_y = '0; b_ascii = '0; b_colour = '0;
        #1 resetn = 0;
        repeat (3) @(negedge clock);
        check("reset_outputs", 64'(dut_vec), 64'(0));
        resetn = 1;

        // single A write
        @(negedge clock);
        a_req = 1; a_x = 7'd5; a_y = 6'd7; a_ascii = 7'h41; a_colour = 6'h0C;
        @(negedge clock);
        check("a_write_data", 64'({wren, wrx, wry, wascii, wcolour, a_ack, hien}),
              64'({1'b1, 7'd5, 6'd7, 7'h41, 6'h0C, 1'b1, 1'b0}));
        check("model_pin_a_write", 64'({e_wren, e_wrx, e_wry, e_a_ack}), 64'({1'b1, 7'd5, 6'd7, 1'b1}));
        a_req = 0;
        @(negedge clock);

        // alternating grants after a fresh reset
        resetn = 0;
        @(negedge clock);
        resetn = 1;
        a_req = 1; a_x = 7'd1; a_y = 6'd1; a_ascii = 7'h31; a_colour = 6'h01;
        b_req = 1; b_x = 7'd2; b_y = 6'd2; b_ascii = 7'h32; b_colour = 6'h02;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("alternate_acks", 64'({a_ack, b_ack, wren}), 64'({(i % 2) == 0, (i % 2) == 1, 1'b1}));
        end
        a_req = 0; b_req = 0;
        @(negedge clock);

        // out-of-bounds write in the small grid
        sL = 1; a_req = 1; a_x = 7'd40; a_y = 6'd0; a_ascii = 7'h42; a_colour = 6'h03;
        @(negedge clock);
        check("oob_ack_no_wren", 64'({a_ack, wren}), 64'(2'b10));
        check("model_pin_oob", 64'({e_a_ack, e_wren}), 64'(2'b10));
        a_req = 0;
        @(negedge clock);

        // 40x30 clear with sL toggled and a stray clr_req mid-way
        clr_req = 1;
        writes = 0; done_cyc = -1; last_cyc = -2; busy_bad = 0; lastx = '0; lasty = '0; done_seen = 0;
        for (int c = 0; c < 1300; c++) begin
            @(negedge clock);
            clr_req = 0;
            if (clr_done) begin
                done_seen = 1; done_cyc = c;
                check("clear_done_quiet", 64'({wren, hien, busy}), 64'(0));
                break;
            end
            if (wren) begin
                writes++; lastx = wrx; lasty = wry; last_cyc = c;
                if (!busy || !hien) busy_bad++;
            end
            if (writes == 300) clr_req = 1;
            if (writes == 600) sL = 0;
        end
        check("small_clear_done_seen", 64'(done_seen), 64'(1));
        check("small_clear_writes", 64'(writes), 64'(1200));
        check("small_clear_busy", 64'(busy_bad), 64'(0));
        check("small_clear_last_cell", 64'({lastx, lasty}), 64'({7'd39, 6'd29}));
        check("small_clear_done_timing", 64'(done_cyc), 64'(last_cyc + 1));
        sL = 0;
        @(negedge clock);

        // clear takes priority over a simultaneous A request
        clr_req = 1; a_req = 1; a_x = 7'd3; a_y = 6'd4; a_ascii = 7'h5A; a_colour = 6'h15;
        writes = 0; ack_during = 0; done_seen = 0;
        for (int c = 0; c < 4900; c++) begin
            @(negedge clock);
            clr_req = 0;
            if (a_ack) ack_during++;
            if (clr_done) begin
                done_seen = 1;
                break;
            end
            if (wren) writes++;
        end
        check("big_clear_done_seen", 64'(done_seen), 64'(1));
        check("big_clear_writes", 64'(writes), 64'(4800));
        check("stalled_a_no_ack", 64'(ack_during), 64'(0));
        @(negedge clock);
        check("a_after_clear", 64'({a_ack, wren, wrx, wry}), 64'({1'b1, 1'b1, 7'd3, 6'd4}));
        a_req = 0;
        @(negedge clock);

        // reset in the middle of a clear
        clr_req = 1; hit = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            clr_req = 0;
            if (wren && wrx == 7'd20 && wry == 6'd1) begin
                hit = 1;
                break;
            end
        end
        check("reached_cell_100", 64'(hit), 64'(1));
        #2 resetn = 0;
        #1 check("async_reset_outputs", 64'(dut_vec), 64'(0));
        @(negedge clock);
        resetn = 1;
        bad_done = 0; bad_wr = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (clr_done) bad_done++;
            if (wren || hien) bad_wr++;
        end
        check("abort_no_done", 64'(bad_done), 64'(0));
        check("abort_no_writes", 64'(bad_wr), 64'(0));

        // randomized requesters; every cycle is checked by the model compare
        nclr = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            clr_req = 0;
            if (a_req && a_ack) begin
                a_req = ($urandom_range(0, 1) == 1);
                a_x = 7'($urandom_range(0, 127)); a_y = 6'($urandom_range(0, 63));
                a_ascii = 7'($urandom); a_colour = 6'($urandom);
            end else if (!a_req && $urandom_range(0, 99) < 35) begin
                a_req = 1;
                a_x = 7'($urandom_range(0, 127)); a_y = 6'($urandom_range(0, 63));
                a_ascii = 7'($urandom); a_colour = 6'($urandom);
            end
            if (b_req && b_ack) begin
                b_req = ($urandom_range(0, 1) == 1);
                b_x = 7'($urandom_range(0, 127)); b_y = 6'($urandom_range(0, 63));
                b_ascii = 7'($urandom); b_colour = 6'($urandom);
            end else if (!b_req && $urandom_range(0, 99) < 35) begin
                b_req = 1;
                b_x = 7'($urandom_range(0, 127)); b_y = 6'($urandom_range(0, 63));
                b_ascii = 7'($urandom); b_colour = 6'($urandom);
            end
            if ($urandom_range(0, 9) == 0) sL = ~sL;
            if (nclr < 3 && $urandom_range(0, 599) == 0) begin
                clr_req = 1;
                nclr++;
            end
        end
        clr_req = 0; a_req = 0; b_req = 0;
        repeat (3) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/char_write_scheduler.md
CHAR_WRITE_SCHEDULER -- requirements
Module: char_write_scheduler

Interface
REQ-001 SHALL have parameter CLR_ASCII, default 7'h20, the character written by screen clear.
REQ-002 SHALL have parameter CLR_COLOUR, default 6'b111111, the colour written by screen clear.
REQ-003 SHALL have parameter CLR_HL, default 1'b0, the highlight bit written by screen clear.
REQ-004 SHALL have port clock  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port sL  in  1  grid select: 0 = 80x60, 1 = 40x30.
REQ-007 SHALL have port clr_req  in  1  single-cycle request to clear the whole active grid.
REQ-008 SHALL have ports a_req in 1, a_x in 7, a_y in 6, a_ascii in 7, a_colour in 6  requester A cell write.
REQ-009 SHALL have port a_ack  out  1  one-cycle grant acknowledge to A.
REQ-010 SHALL have ports b_req, b_x, b_y, b_ascii, b_colour, b_ack, identical to A, for requester B.
REQ-011 SHALL have ports wrx out 7, wry out 6, wren out 1, wascii out 7, wcolour out 6  character/colour write port.
REQ-012 SHALL have ports hix out 7, hiy out 6, hien out 1, highlight out 1  highlight write port.
REQ-013 SHALL have port busy  out  1  high while a clear is in progress.
REQ-014 SHALL have port clr_done  out  1  one-cycle pulse when a clear completes.

Function
REQ-015 SHALL register every output; no input reaches an output combinationally.
REQ-016 SHALL implement the states IDLE and CLEAR.
REQ-017 In IDLE, clr_req=1 SHALL move to CLEAR; clr_req SHALL take priority over a_req and b_req in the same cycle.
REQ-018 In IDLE with no clr_req, an eligible requester SHALL be granted; the next cycle then has wren=1 and the requester's x/y/ascii/colour on the write port, with its ack=1.
REQ-019 A requester whose ack is high in the current cycle SHALL be ineligible that cycle.
  - A single requester gets at most one write every two cycles.
  - A and B alternating get one write per cycle.
REQ-020 Arbitration SHALL be round-robin: when both are eligible, the one not granted last wins; last-grant resets to B, so A wins the first tie.
REQ-021 A requester SHALL hold req and data stable until ack; data is sampled on the grant edge.
REQ-022 A granted write whose coordinates are out of bounds SHALL still be acked, but with wren=0.
  - Bounds: x>=80 or y>=60 when sL=0; x>=40 or y>=30 when sL=1.
REQ-023 Requester writes SHALL drive hien=0.
REQ-024 Entering CLEAR SHALL latch sL into an internal copy used for the whole clear; sL changes during a clear SHALL have no effect.
REQ-025 CLEAR SHALL write one cell per cycle, x fastest, from (0,0) to (W-1,H-1), on both ports.
  - Character port: wren=1, wascii=CLR_ASCII, wcolour=CLR_COLOUR.
  - Highlight port: hien=1, highlight=CLR_HL, hix/hiy equal to wrx/wry.
  - Total: exactly W*H write cycles (4800 for sL=0, 1200 for sL=1).
REQ-026 busy SHALL be 1 from the first clear write cycle through the last.
REQ-027 clr_done SHALL pulse for the single cycle after the last clear write, with wren=hien=0 and the FSM back in IDLE.
REQ-028 clr_req during CLEAR SHALL be ignored.
REQ-029 a_req/b_req during CLEAR SHALL stall without ack and SHALL be arbitrated normally after return to IDLE.
REQ-030 x/y counters SHALL wrap x to 0 and increment y at x=W-1, with no overflow beyond H-1.

Reset
REQ-031 resetn=0 SHALL immediately force:
  - state IDLE, counters 0, last-grant = B;
  - all outputs 0: wrx, wry, wren, wascii, wcolour, hix, hiy, hien, highlight, a_ack, b_ack, busy, clr_done.
REQ-032 Reset during CLEAR SHALL abort it, with no clr_done pulse and no further writes.

Verification
REQ-033 A bench SHALL apply a_req with (5,7,'A',6'h0C) in IDLE and check: the next cycle has wren=1, wrx=5, wry=7, wascii=7'h41, wcolour=6'h0C, a_ack=1, hien=0.
REQ-034 A bench SHALL hold a_req and b_req high for 6 cycles and check acks alternate A,B,A,B with A first after reset, and one write per cycle.
REQ-035 A bench SHALL pulse clr_req with sL=1 and check:
  - 1200 writes with busy=1, last cell (39,29);
  - clr_done one cycle later;
  - toggling sL mid-clear changes nothing.
REQ-036 A bench SHALL assert clr_req and a_req in the same cycle and check that clear starts, a_ack stays 0 for all 4800 cycles (sL=0), and A is acked right after clr_done.
REQ-037 A bench SHALL apply a_req with (40,0) at sL=1 and check a_ack=1 with wren=0.
REQ-038 A bench SHALL drop resetn at clear cell 100 and check that all outputs go 0 asynchronously and clr_done never pulses.
